// File: rtl/pwl_limiter_pkg.sv
// Shared types and saturating helpers for the pwl_limiter_array channels.
// The helpers take the target width at the call site, so one copy serves every width.
package pwl_limiter_pkg;

    typedef enum logic [1:0] {
        TRACK  = 2'd0,
        SAT_HI = 2'd1,
        SAT_LO = 2'd2
    } lim_state_t;

    // Clamp a sign-extended value into the two's complement range of a w-bit word (w <= 63).
    function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    // Increment an unsigned w-bit count, holding at all-ones instead of wrapping (w <= 31).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] top;
        top = (32'd1 << w) - 32'd1;
        if (v >= top) begin
            return top;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/pwl_limiter_ch.sv
// One channel's clamp stage: limit decision, TRACK/SAT_HI/SAT_LO state and event counter.
// Defining PWL_LIMITER_SLEW_EN adds a per-sample slew limiter after the clamp.
module pwl_limiter_ch #(
    parameter int W      = 16,
    parameter int CW     = 8,
    parameter bit NO_MAX = 1'b0,
    parameter bit NO_MIN = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid,
    input  logic signed [W-1:0] g,
    input  logic signed [W-1:0] maxout,
    input  logic signed [W-1:0] minout,
    input  logic        [W-1:0] max_step,
    input  logic                cnt_clr,
    output logic signed [W-1:0] out_data,
    output logic                sat_hi,
    output logic                sat_lo,
    output logic       [CW-1:0] sat_cnt
);
    import pwl_limiter_pkg::*;

    lim_state_t          state;
    lim_state_t          next_state;
    lim_state_t          target;
    logic signed [W-1:0] clamped;
    logic signed [W-1:0] out_q;
    logic signed [W-1:0] out_next;
    logic                event_hit;
    logic       [CW-1:0] cnt_q;

    // The upper test runs first, so an inverted range (minout > maxout) resolves to maxout.
    always_comb begin
        target    = TRACK;
        clamped   = g;
        if (!NO_MAX && (g >= maxout)) begin
            clamped = maxout;
            target  = SAT_HI;
        end else if (!NO_MIN && (g <= minout)) begin
            clamped = minout;
            target  = SAT_LO;
        end
        next_state = valid ? target : state;
        event_hit  = valid && (target != TRACK) && (target != state);
    end

`ifdef PWL_LIMITER_SLEW_EN
    logic signed [W+1:0] prev_ext;
    logic signed [W+1:0] step_ext;
    logic signed [W+1:0] diff;

    // Two guard bits keep the difference and the unsigned step comparable without overflow.
    always_comb begin
        prev_ext = (W+2)'(out_q);
        step_ext = {2'b00, max_step};
        diff     = (W+2)'(clamped) - prev_ext;
        out_next = clamped;
        if (diff > step_ext) begin
            out_next = W'(prev_ext + step_ext);
        end else if (diff < -step_ext) begin
            out_next = W'(prev_ext - step_ext);
        end
    end
`else
    logic unused_max_step;
    assign unused_max_step = ^max_step;
    assign out_next        = clamped;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= TRACK;
        end else begin
            state <= next_state;
        end
    end

    // A clear wins over an event landing in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            if (valid) begin
                out_q <= out_next;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (event_hit) begin
                cnt_q <= CW'(sat_inc(32'(cnt_q), CW));
            end
        end
    end

    assign out_data = out_q;
    assign sat_hi   = (state == SAT_HI);
    assign sat_lo   = (state == SAT_LO);
    assign sat_cnt  = cnt_q;

endmodule

// File: rtl/pwl_limiter_array.sv
// N-channel fixed-point gain/clamp limiter with a fixed two-cycle latency.
// Defining PWL_LIMITER_SLEW_EN enables slew limiting in every channel.
module pwl_limiter_array #(
    parameter int NCH    = 4,
    parameter int W      = 16,
    parameter int FRAC   = 8,
    parameter int CW     = 8,
    parameter bit NO_MAX = 1'b0,
    parameter bit NO_MIN = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    input  logic [NCH*W-1:0]    in_data,
    input  logic signed [W-1:0] gain,
    input  logic signed [W-1:0] maxout,
    input  logic signed [W-1:0] minout,
    input  logic [W-1:0]        max_step,
    input  logic                cnt_clr,
    output logic                out_valid,
    output logic [NCH*W-1:0]    out_data,
    output logic [NCH-1:0]      sat_hi,
    output logic [NCH-1:0]      sat_lo,
    output logic [NCH*CW-1:0]   sat_cnt
);
    import pwl_limiter_pkg::*;

    logic signed [W-1:0] g_comb [NCH];
    logic signed [W-1:0] s1_g   [NCH];
    logic                s1_valid;
    logic signed [W-1:0] s1_max;
    logic signed [W-1:0] s1_min;
    logic        [W-1:0] s1_step;

    for (genvar k = 0; k < NCH; k++) begin : g_gain
        logic signed [W-1:0]   in_k;
        logic signed [2*W-1:0] prod;
        logic signed [2*W-1:0] shifted;

        assign in_k       = $signed(in_data[k*W +: W]);
        assign prod       = in_k * gain;
        assign shifted    = prod >>> FRAC;
        assign g_comb[k]  = W'(sat_to_w(64'(shifted), W));
    end

    // Limits travel with their sample so a mid-stream change only hits later samples.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_max   <= '0;
            s1_min   <= '0;
            for (int k = 0; k < NCH; k++) begin
                s1_g[k] <= '0;
            end
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_max <= maxout;
                s1_min <= minout;
                for (int k = 0; k < NCH; k++) begin
                    s1_g[k] <= g_comb[k];
                end
            end
        end
    end

`ifdef PWL_LIMITER_SLEW_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_step <= '0;
        end else if (in_valid) begin
            s1_step <= max_step;
        end
    end
`else
    logic unused_top_step;
    assign unused_top_step = ^max_step;
    assign s1_step         = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_valid;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        pwl_limiter_ch #(
            .W      (W),
            .CW     (CW),
            .NO_MAX (NO_MAX),
            .NO_MIN (NO_MIN)
        ) u_ch (
            .clk      (clk),
            .rstn     (rstn),
            .valid    (s1_valid),
            .g        (s1_g[k]),
            .maxout   (s1_max),
            .minout   (s1_min),
            .max_step (s1_step),
            .cnt_clr  (cnt_clr),
            .out_data (out_data[k*W +: W]),
            .sat_hi   (sat_hi[k]),
            .sat_lo   (sat_lo[k]),
            .sat_cnt  (sat_cnt[k*CW +: CW])
        );
    end

endmodule

// File: doc/pwl_limiter_array.md
Name: pwl_limiter_array

Overview:
- Clocked, N-channel, fixed-point successor to the event-driven PWL limiter.
- Each channel applies a gain, clamps to run-time upper/lower limits, and optionally limits slew.
- Tracks saturation state and counts saturation events per channel.
- Sits between sampled ADC/DSP front-ends and digital behavioural models of compressing amplifiers in mixed-signal testbenches.

Parameters:
- NCH, 4: number of independent channels.
- W, 16: signed data width (two's complement) of inputs, limits and outputs.
- FRAC, 8: fractional bits of gain; gain is signed Q(W-FRAC).FRAC.
- CW, 8: width of each per-channel saturation-event counter.
- NO_MAX, 1'b0: if 1, upper limit ignored (no SAT_HI).
- NO_MIN, 1'b0: if 1, lower limit ignored (no SAT_LO).

Ports:
- clk  in  1  sampling clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample vector valid this cycle.
- in_data  in  NCH*W  channel k at bits [k*W +: W], signed.
- gain  in  W  signed Q.FRAC gain, shared by all channels, sampled with in_valid.
- maxout  in  W  signed upper limit, sampled with in_valid.
- minout  in  W  signed lower limit, sampled with in_valid.
- max_step  in  W  unsigned maximum per-sample output change (slew feature only).
- cnt_clr  in  1  synchronous clear of all event counters.
- out_valid  out  1  output vector valid.
- out_data  out  NCH*W  limited outputs, same packing as in_data.
- sat_hi  out  NCH  channel currently in SAT_HI.
- sat_lo  out  NCH  channel currently in SAT_LO.
- sat_cnt  out  NCH*CW  per-channel saturation-event counts.

Behaviour:
- Reset (rstn=0, asynchronous):
  - out_valid=0, out_data=0, sat_hi=0, sat_lo=0, sat_cnt=0.
  - Pipeline valids cleared; all channels enter TRACK.
  - Reset mid-stream discards in-flight samples; there is no partial output.
- Pipeline and timing:
  - Fixed 2-cycle latency: sample accepted at edge n appears on out_* after edge n+2.
  - No backpressure; in_valid may be high every cycle.
  - out_valid is in_valid delayed by 2.
  - State, counters and the previous-output register update only on valid samples.
- Stage 1 (gain):
  - p = in*gain is a full 2W-bit signed product.
  - g = p >>> FRAC, arithmetic shift, truncation toward minus infinity.
  - g saturates to [-2^(W-1), 2^(W-1)-1].
- Stage 2 (clamp):
  - If !NO_MAX and g >= maxout: c = maxout, target state SAT_HI.
  - Else if !NO_MIN and g <= minout: c = minout, target state SAT_LO.
  - Else c = g, target state TRACK.
  - Precedence on an inverted range (minout > maxout, both enabled): upper test wins, so out = maxout. This is deterministic and must be checked.
  - Equality counts as saturated, same as the event-driven version.
- Per-channel FSM states: TRACK, SAT_HI, SAT_LO.
  - Transitions occur directly to the target state on each valid sample.
  - Direct SAT_HI<->SAT_LO transitions are allowed.
- Event counter:
  - Increments on every valid-sample transition from TRACK or the opposite SAT state into SAT_HI or SAT_LO.
  - Remaining in a SAT state does not count.
  - Saturates at 2^CW-1; does not wrap.
  - cnt_clr has priority over increment in the same cycle, so the count becomes 0.
- sat_hi and sat_lo are registered with out_data; they are never both high.
- Limits and gain are captured with the sample, so a mid-stream change affects only later samples.

Optional Feature:
- Macro: PWL_LIMITER_SLEW_EN.
- With the macro defined, stage 2 limits slew after the clamp, per channel:
  - d = c - prev (W+1 bits).
  - If d > max_step: out = prev + max_step.
  - If d < -max_step: out = prev - max_step.
  - Otherwise out = c.
  - prev is the last output (0 after reset).
  - sat flags and the FSM follow the clamp decision, not the slewed value.
  - max_step = 0 freezes the output at prev.
- Without the macro: out = c; max_step is ignored and there is no prev register.

Decomposition:
- Shared package pwl_limiter_pkg:
  - typedef enum logic[1:0] {TRACK, SAT_HI, SAT_LO} lim_state_t.
  - Saturating-add and saturate-to-W function templates, parameterised by width.
- One sub-module, pwl_limiter_ch, holds one channel's stage-2 logic, FSM and counter.
- The top instantiates NCH copies via generate; stage 1 stays in the top.

Test Plan (W=16, FRAC=8, NCH=4):
- Reset, then gain=0x0100 (1.0), max=1000, min=-1000, in={0,500,999,-999} -> after 2 cycles out equals in, all flags 0, counts 0.
- in ch0 steps 0 -> 1200 -> 1500 -> 0 -> out 1000, 1000, 0; sat_hi pulse for 2 samples; sat_cnt[0]=1.
- gain=0x0200 (2.0), in=20000 -> product saturates to 32767, clamps to 1000; in=-20000 -> out=-1000; sat_cnt increments on the direct HI->LO transition.
- minout=500, maxout=100, in=300 -> out=100, sat_hi=1.
- Counter reaches 255 via alternating HI/LO inputs -> holds at 255; cnt_clr asserted with a new event -> 0.
- With PWL_LIMITER_SLEW_EN, max_step=100, in 0 -> 800 -> out ramps 100, 200, ... 800 over 8 samples with sat flags 0; assert rstn low mid-ramp -> out 0, out_valid 0 immediately.
